// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FCR trigger-level codes, LSR bit
// positions, error-tag field order and the character-timeout FSM states.
package uart_pkg;

  localparam logic [1:0] TL_1  = 2'b00;
  localparam logic [1:0] TL_4  = 2'b01;
  localparam logic [1:0] TL_8  = 2'b10;
  localparam logic [1:0] TL_14 = 2'b11;

  localparam int LSR_DR      = 0;
  localparam int LSR_OE      = 1;
  localparam int LSR_PE      = 2;
  localparam int LSR_FE      = 3;
  localparam int LSR_BI      = 4;
  localparam int LSR_FIFOERR = 7;

  // Error tag is {BI,FE,PE}
  localparam int ERR_PE = 0;
  localparam int ERR_FE = 1;
  localparam int ERR_BI = 2;

  typedef enum logic [1:0] {
    TO_IDLE    = 2'd0,
    TO_COUNT   = 2'd1,
    TO_EXPIRED = 2'd2
  } to_state_e;

  function automatic int unsigned trig_level(input logic fifoen, input logic [1:0] sel);
    if (!fifoen) return 1;
    case (sel)
      TL_1:    return 1;
      TL_4:    return 4;
      TL_8:    return 8;
      default: return 14;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the RX FIFO and its neighbours: FCR controls, deserializer
// write side, CPU read side and the status flags feeding LSR/IIR.
interface uart_rx_fifo_if #(parameter int DEPTH = 16);
  import uart_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);

  // Strobes are single-cycle. A write is accepted when the FIFO is not full or
  // a pop happens in the same cycle; a pop is accepted only while data_ready=1.
  logic          FIFOEN;
  logic          RXCLR;
  logic [1:0]    RXFIFTL;
  logic          rx_wr_en;
  logic [7:0]    rx_wr_data;
  logic [2:0]    rx_wr_err;
  logic          rx_rd_en;
  logic          lsr_rd;
  logic          char_tick;
  logic [7:0]    rx_rd_data;
  logic [2:0]    rx_rd_err;
  logic          data_ready;
  logic          overrun_err;
  logic          fifo_err;
  logic          trigger_int;
  logic          timeout_int;
  logic [CW-1:0] rx_count;
  to_state_e     to_state;

  modport master (
    output FIFOEN, RXCLR, RXFIFTL, rx_wr_en, rx_wr_data, rx_wr_err,
           rx_rd_en, lsr_rd, char_tick,
    input  rx_rd_data, rx_rd_err, data_ready, overrun_err, fifo_err,
           trigger_int, timeout_int, rx_count, to_state
  );

  modport slave (
    input  FIFOEN, RXCLR, RXFIFTL, rx_wr_en, rx_wr_data, rx_wr_err,
           rx_rd_en, lsr_rd, char_tick,
    output rx_rd_data, rx_rd_err, data_ready, overrun_err, fifo_err,
           trigger_int, timeout_int, rx_count, to_state
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Storage array for the RX FIFO: synchronous write, asynchronous read so the
// head entry is visible without a read cycle.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 11,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550-style receive FIFO: pointers, occupancy and error-entry counters,
// sticky overrun and the character-timeout FSM.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TO_CHARS = 4
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TO_CHARS + 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, err_cnt_q, err_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ovr_q, ovr_d, fifoen_q;
  to_state_e     state_q, state_d;

  logic [10:0]   head;
  logic [CW-1:0] depth_eff, trig_lvl;
  logic          clr, full, empty, push, pop, drop, to_restart;

  // Toggling FIFOEN changes the effective depth, so it flushes like RXCLR.
  assign clr       = bus.RXCLR | (bus.FIFOEN != fifoen_q);
  assign depth_eff = bus.FIFOEN ? CW'(DEPTH) : CW'(1);
  assign full      = (count_q >= depth_eff);
  assign empty     = (count_q == '0);
  assign pop       = bus.rx_rd_en & ~empty & ~clr;
  assign push      = bus.rx_wr_en & ~clr & (~full | pop);
  assign drop      = bus.rx_wr_en & ~clr & full & ~pop;

  uart_fifo_mem #(.DEPTH(DEPTH), .W(11)) u_mem (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({bus.rx_wr_err, bus.rx_wr_data}),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    ovr_d     = ovr_q;
    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_d + CW'(1);
        if (|bus.rx_wr_err) err_cnt_d = err_cnt_d + CW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_d - CW'(1);
        if (|head[10:8]) err_cnt_d = err_cnt_d - CW'(1);
      end
    end
    if (drop)            ovr_d = 1'b1;
    else if (bus.lsr_rd) ovr_d = 1'b0;
  end

  assign to_restart = push | pop | clr | empty | ~bus.FIFOEN;

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    if (to_restart) begin
      state_d  = TO_IDLE;
      to_cnt_d = '0;
    end else if (bus.char_tick) begin
      case (state_q)
        TO_IDLE, TO_COUNT: begin
          to_cnt_d = to_cnt_q + TW'(1);
          state_d  = (to_cnt_d == TW'(TO_CHARS)) ? TO_EXPIRED : TO_COUNT;
        end
        default: begin
          state_d  = TO_EXPIRED;
          to_cnt_d = to_cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      to_cnt_q  <= '0;
      ovr_q     <= 1'b0;
      fifoen_q  <= bus.FIFOEN;
      state_q   <= TO_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ovr_q     <= ovr_d;
      fifoen_q  <= bus.FIFOEN;
      state_q   <= state_d;
    end
  end

  assign trig_lvl        = CW'(trig_level(bus.FIFOEN, bus.RXFIFTL));
  assign bus.rx_rd_data  = head[7:0];
  assign bus.rx_rd_err   = head[10:8];
  assign bus.data_ready  = ~empty;
  assign bus.overrun_err = ovr_q;
  assign bus.fifo_err    = (err_cnt_q != '0);
  assign bus.trigger_int = (count_q >= trig_lvl);
  assign bus.timeout_int = (state_q == TO_EXPIRED) & ~empty;
  assign bus.rx_count    = count_q;
  assign bus.to_state    = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH    = 16;
  localparam int TO_CHARS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .TO_CHARS(TO_CHARS)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // ---------------- model state ----------------
  logic [10:0] exp_q[$];
  logic        m_ovr = 1'b0;
  int          m_tcnt = 0;
  logic        m_prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_trig_level();
    if (!bus.FIFOEN) return 1;
    case (bus.RXFIFTL)
      2'd0: return 1;
      2'd1: return 4;
      2'd2: return 8;
      default: return 14;
    endcase
  endfunction

  function automatic logic m_any_err();
    foreach (exp_q[i]) if (exp_q[i][10:8] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int   depth;
    int   old_size;
    logic do_pop, do_push, full;
    if (!rst) begin
      exp_q.delete();
      m_ovr     = 1'b0;
      m_tcnt    = 0;
      m_prev_en = bus.FIFOEN;
    end else if (bus.RXCLR || (bus.FIFOEN != m_prev_en)) begin
      m_prev_en = bus.FIFOEN;
      exp_q.delete();
      m_tcnt = 0;
      if (bus.lsr_rd) m_ovr = 1'b0;
    end else begin
      depth    = bus.FIFOEN ? DEPTH : 1;
      old_size = exp_q.size();
      full     = (old_size >= depth);
      do_pop   = bus.rx_rd_en && (old_size > 0);
      do_push  = bus.rx_wr_en && (!full || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({bus.rx_wr_err, bus.rx_wr_data});
      if (bus.rx_wr_en && full && !do_pop) m_ovr = 1'b1;
      else if (bus.lsr_rd)                 m_ovr = 1'b0;
      if (do_push || do_pop || old_size == 0 || !bus.FIFOEN) m_tcnt = 0;
      else if (bus.char_tick && m_tcnt < TO_CHARS)           m_tcnt++;
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [7:0] lsr_act, lsr_exp;
    if (rst && cmp_en) begin
      lsr_act = '0;
      lsr_exp = '0;
      lsr_act[LSR_DR]      = bus.data_ready;
      lsr_act[LSR_OE]      = bus.overrun_err;
      lsr_act[LSR_FIFOERR] = bus.fifo_err;
      lsr_exp[LSR_DR]      = (exp_q.size() != 0);
      lsr_exp[LSR_OE]      = m_ovr;
      lsr_exp[LSR_FIFOERR] = m_any_err();
      if (exp_q.size() != 0) begin
        lsr_act[LSR_PE] = bus.rx_rd_err[ERR_PE];
        lsr_act[LSR_FE] = bus.rx_rd_err[ERR_FE];
        lsr_act[LSR_BI] = bus.rx_rd_err[ERR_BI];
        lsr_exp[LSR_PE] = exp_q[0][8 + ERR_PE];
        lsr_exp[LSR_FE] = exp_q[0][8 + ERR_FE];
        lsr_exp[LSR_BI] = exp_q[0][8 + ERR_BI];
        check("head_data", 32'(bus.rx_rd_data), 32'(exp_q[0][7:0]));
      end
      check("lsr", 32'(lsr_act), 32'(lsr_exp));
      check("rx_count", 32'(bus.rx_count), 32'(exp_q.size()));
      check("trigger_int", 32'(bus.trigger_int), 32'(exp_q.size() >= m_trig_level()));
      check("timeout_int", 32'(bus.timeout_int),
            32'((m_tcnt == TO_CHARS) && (exp_q.size() != 0)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    bus.rx_wr_en  = 1'b0;
    bus.rx_rd_en  = 1'b0;
    bus.RXCLR     = 1'b0;
    bus.lsr_rd    = 1'b0;
    bus.char_tick = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] e);
    bus.rx_wr_en   = 1'b1;
    bus.rx_wr_data = d;
    bus.rx_wr_err  = e;
    step();
  endtask

  task automatic pop_expect(input logic [7:0] d);
    @(negedge clk);
    check("pop_data", 32'(bus.rx_rd_data), 32'(d));
    bus.rx_rd_en = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] tag_fe;
    int         wr_pct, rd_pct;

    bus.FIFOEN     = 1'b1;
    bus.RXCLR      = 1'b0;
    bus.RXFIFTL    = 2'b00;
    bus.rx_wr_en   = 1'b1;
    bus.rx_wr_data = 8'hAA;
    bus.rx_wr_err  = 3'b000;
    bus.rx_rd_en   = 1'b0;
    bus.lsr_rd     = 1'b0;
    bus.char_tick  = 1'b0;

    // Reset held two cycles with a write strobe active: nothing may be stored.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.rx_wr_en = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    check("rst_count", 32'(bus.rx_count), 32'd0);
    check("rst_dr", 32'(bus.data_ready), 32'd0);
    check("rst_oe", 32'(bus.overrun_err), 32'd0);
    check("rst_ferr", 32'(bus.fifo_err), 32'd0);
    check("rst_trig", 32'(bus.trigger_int), 32'd0);
    check("rst_to", 32'(bus.timeout_int), 32'd0);
    check("rst_data", 32'(bus.rx_rd_data), 32'd0);
    check("rst_state", 32'(bus.to_state), 32'(TO_IDLE));

    // Trigger level 4.
    bus.RXFIFTL = TL_4;
    push(8'h11, 3'b000);
    push(8'h12, 3'b000);
    push(8'h13, 3'b000);
    @(negedge clk);
    check("trig_at3", 32'(bus.trigger_int), 32'd0);
    push(8'h14, 3'b000);
    @(negedge clk);
    check("trig_at4", 32'(bus.trigger_int), 32'd1);
    check("count_at4", 32'(bus.rx_count), 32'd4);
    for (int i = 0; i < 4; i++) pop_expect(8'(8'h11 + i));

    // 17 pushes into a 16-deep FIFO.
    for (int i = 1; i <= 17; i++) push(8'(i), 3'b000);
    @(negedge clk);
    check("ovf_count", 32'(bus.rx_count), 32'd16);
    check("ovf_oe", 32'(bus.overrun_err), 32'd1);
    for (int i = 1; i <= 16; i++) pop_expect(8'(i));
    @(negedge clk);
    check("ovf_oe_sticky", 32'(bus.overrun_err), 32'd1);
    bus.lsr_rd = 1'b1;
    step();
    @(negedge clk);
    check("oe_cleared", 32'(bus.overrun_err), 32'd0);

    // Full FIFO with simultaneous push and pop, across the pointer wrap.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 3'b000);
    for (int k = 0; k < 3; k++) begin
      bus.rx_rd_en = 1'b1;
      push(8'(8'h30 + k), 3'b000);
    end
    @(negedge clk);
    check("full_rw_oe", 32'(bus.overrun_err), 32'd0);
    check("full_rw_count", 32'(bus.rx_count), 32'd16);
    for (int i = 0; i < 16; i++)
      pop_expect((i < 13) ? 8'(8'h23 + i) : 8'(8'h30 + i - 13));
    bus.rx_rd_en = 1'b1;
    step();
    @(negedge clk);
    check("underflow_count", 32'(bus.rx_count), 32'd0);

    // Character timeout.
    push(8'h41, 3'b000);
    push(8'h42, 3'b000);
    for (int t = 1; t <= 4; t++) begin
      bus.char_tick = 1'b1;
      step();
      @(negedge clk);
      if (t == 3) check("to_tick3", 32'(bus.timeout_int), 32'd0);
      if (t == 4) check("to_tick4", 32'(bus.timeout_int), 32'd1);
    end
    pop_expect(8'h41);
    @(negedge clk);
    check("to_after_pop", 32'(bus.timeout_int), 32'd0);
    bus.RXCLR = 1'b1;
    step();

    // Error tag, then clear racing a push.
    tag_fe = '0;
    tag_fe[ERR_FE] = 1'b1;
    push(8'h55, tag_fe);
    @(negedge clk);
    check("ferr_set", 32'(bus.fifo_err), 32'd1);
    check("ferr_tag", 32'(bus.rx_rd_err), 32'(3'b010));
    bus.RXCLR = 1'b1;
    push(8'h66, 3'b000);
    @(negedge clk);
    check("clr_count", 32'(bus.rx_count), 32'd0);
    check("clr_ferr", 32'(bus.fifo_err), 32'd0);

    // Holding-register mode.
    bus.FIFOEN = 1'b0;
    step();
    push(8'hA1, 3'b000);
    push(8'hA2, 3'b000);
    @(negedge clk);
    check("hr_oe", 32'(bus.overrun_err), 32'd1);
    check("hr_count", 32'(bus.rx_count), 32'd1);
    check("hr_trig", 32'(bus.trigger_int), 32'd1);
    pop_expect(8'hA1);
    bus.lsr_rd = 1'b1;
    step();
    bus.FIFOEN = 1'b1;
    step();

    // Randomized traffic in fill, drain and quiet phases.
    for (int i = 0; i < 4000; i++) begin
      case ((i / 250) % 3)
        0:       begin wr_pct = 70; rd_pct = 20; end
        1:       begin wr_pct = 20; rd_pct = 70; end
        default: begin wr_pct = 3;  rd_pct = 3;  end
      endcase
      bus.rx_wr_en   = ($urandom_range(0, 99) < wr_pct);
      bus.rx_wr_data = 8'($urandom);
      bus.rx_wr_err  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      bus.rx_rd_en   = ($urandom_range(0, 99) < rd_pct);
      bus.char_tick  = ($urandom_range(0, 2) == 0);
      bus.lsr_rd     = ($urandom_range(0, 19) == 0);
      bus.RXCLR      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 499) == 0) bus.FIFOEN = ~bus.FIFOEN;
      if ($urandom_range(0, 49) == 0) bus.RXFIFTL = 2'($urandom);
      step();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
